// File: rtl/mem_scrub_ctrl.sv
// rtl/mem_scrub_ctrl.sv - block RAM fill/verify sequencer and user/engine port arbiter
module mem_scrub_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 18,
  parameter int DEPTH     = 4096,
  parameter int STALL_MAX = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_start,
  input  logic              i_cmd_mode,
  input  logic [DATA_W-1:0] i_cmd_pattern,
  input  logic              i_usr_valid,
  input  logic              i_usr_we,
  input  logic [ADDR_W-1:0] i_usr_addr,
  input  logic [DATA_W-1:0] i_usr_wdata,
  output logic              o_usr_ready,
  output logic              o_usr_rvalid,
  output logic [DATA_W-1:0] o_usr_rdata,
  output logic [ADDR_W-1:0] o_mem_raddr,
  output logic [ADDR_W-1:0] o_mem_waddr,
  output logic [DATA_W-1:0] o_mem_din,
  output logic              o_mem_we,
  input  logic [DATA_W-1:0] i_mem_dout,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_flag,
  output logic [ADDR_W:0]   o_err_count,
  output logic [ADDR_W-1:0] o_first_err_addr
);

  localparam int                STALL_W   = $clog2(STALL_MAX + 2);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_MAX   = (ADDR_W + 1)'(DEPTH);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_VERIFY, S_DRAIN, S_DONE} state_t;

  state_t              r_state, w_next;
  logic                r_alive;
  logic                r_mode;
  logic [DATA_W-1:0]   r_pattern;
  logic [ADDR_W-1:0]   r_eaddr;
  logic [STALL_W-1:0]  r_stall;
  logic                r_cmp_valid;
  logic [ADDR_W-1:0]   r_cmp_addr;
  logic                r_err_flag;
  logic [ADDR_W:0]     r_err_count;
  logic [ADDR_W-1:0]   r_first_err;
  logic                r_rvalid;

  logic w_fill, w_verify, w_conflict, w_stall_hit, w_eng_grant;
  logic w_usr_acc, w_usr_wr, w_usr_rd, w_eng_wr, w_eng_rd, w_mismatch, w_start;

  // The engine only contends with the user on the port it is using in the current sweep.
  assign w_fill      = (r_state == S_FILL);
  assign w_verify    = (r_state == S_VERIFY);
  assign w_start     = (r_state == S_IDLE) && i_cmd_start;
  assign w_conflict  = i_usr_valid && ((w_fill && i_usr_we) || (w_verify && !i_usr_we));
  assign w_stall_hit = (r_stall == STALL_LIM);
  assign w_eng_grant = (w_fill || w_verify) && (!w_conflict || w_stall_hit);
  assign w_eng_wr    = w_eng_grant && w_fill;
  assign w_eng_rd    = w_eng_grant && w_verify;
  assign o_usr_ready = r_alive && !(w_conflict && w_stall_hit);
  assign w_usr_acc   = o_usr_ready && i_usr_valid;
  assign w_usr_wr    = w_usr_acc && i_usr_we;
  assign w_usr_rd    = w_usr_acc && !i_usr_we;
  assign w_mismatch  = r_cmp_valid && (i_mem_dout != r_pattern);

  // RAM pins are driven to zero whenever the corresponding port is unused.
  assign o_mem_we    = w_eng_wr || w_usr_wr;
  assign o_mem_waddr = w_eng_wr ? r_eaddr   : (w_usr_wr ? i_usr_addr  : '0);
  assign o_mem_din   = w_eng_wr ? r_pattern : (w_usr_wr ? i_usr_wdata : '0);
  assign o_mem_raddr = w_eng_rd ? r_eaddr   : (w_usr_rd ? i_usr_addr  : '0);

  assign o_usr_rvalid     = r_rvalid;
  assign o_usr_rdata      = r_rvalid ? i_mem_dout : '0;
  assign o_busy           = (r_state != S_IDLE);
  assign o_done           = (r_state == S_DONE);
  assign o_err_flag       = r_err_flag;
  assign o_err_count      = r_err_count;
  assign o_first_err_addr = r_first_err;

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state: the last granted word ends the sweep; verify needs one drain cycle for its final compare.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_cmd_start) w_next = i_cmd_mode ? S_VERIFY : S_FILL;
      S_FILL:   if (w_eng_grant && (r_eaddr == LAST_ADDR)) w_next = S_DONE;
      S_VERIFY: if (w_eng_grant && (r_eaddr == LAST_ADDR)) w_next = S_DRAIN;
      S_DRAIN:  w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Engine address, stall counter, command capture and pending-compare tracking.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_alive     <= 1'b0;
      r_mode      <= 1'b0;
      r_pattern   <= '0;
      r_eaddr     <= '0;
      r_stall     <= '0;
      r_cmp_valid <= 1'b0;
      r_cmp_addr  <= '0;
    end else begin
      r_alive     <= 1'b1;
      r_cmp_valid <= w_eng_rd;
      r_cmp_addr  <= r_eaddr;
      if (w_start) begin
        r_mode    <= i_cmd_mode;
        r_pattern <= i_cmd_pattern;
        r_eaddr   <= '0;
        r_stall   <= '0;
      end else if (w_eng_grant) begin
        r_eaddr <= r_eaddr + ADDR_W'(1);
        r_stall <= '0;
      end else if (w_conflict) begin
        r_stall <= r_stall + STALL_W'(1);
      end
    end
  end

  // Verify status: first mismatch address is latched once, count saturates at the sweep length.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_err_flag  <= 1'b0;
      r_err_count <= '0;
      r_first_err <= '0;
    end else if (w_start) begin
      r_err_flag  <= 1'b0;
      r_err_count <= '0;
      r_first_err <= '0;
    end else if (w_mismatch) begin
      r_err_flag <= 1'b1;
      if (!r_err_flag) r_first_err <= r_cmp_addr;
      if (r_err_count != CNT_MAX) r_err_count <= r_err_count + (ADDR_W + 1)'(1);
    end
  end

  // User read data is the RAM output one cycle after an accepted read.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_rvalid <= 1'b0;
    else         r_rvalid <= w_usr_rd;
  end

endmodule

// File: tb/tb_mem_scrub_ctrl.sv
// tb/tb_mem_scrub_ctrl.sv - self-checking bench for mem_scrub_ctrl
module tb_mem_scrub_ctrl;
  localparam int AW = 12;
  localparam int DW = 18;
  localparam int DEPTH = 4096;
  localparam int SMAX = 8;

  logic clk = 1'b0;
  logic reset;
  logic cmd_start, cmd_mode;
  logic [DW-1:0] cmd_pattern;
  logic usr_valid, usr_we;
  logic [AW-1:0] usr_addr;
  logic [DW-1:0] usr_wdata;
  logic usr_ready, usr_rvalid;
  logic [DW-1:0] usr_rdata;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [DW-1:0] mem_din, mem_dout;
  logic mem_we, busy, done, err_flag;
  logic [AW:0] err_count;
  logic [AW-1:0] first_err_addr;

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  mem_scrub_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .STALL_MAX(SMAX)) dut (
    .i_clk(clk), .i_reset(reset), .i_cmd_start(cmd_start), .i_cmd_mode(cmd_mode),
    .i_cmd_pattern(cmd_pattern), .i_usr_valid(usr_valid), .i_usr_we(usr_we),
    .i_usr_addr(usr_addr), .i_usr_wdata(usr_wdata), .o_usr_ready(usr_ready),
    .o_usr_rvalid(usr_rvalid), .o_usr_rdata(usr_rdata), .o_mem_raddr(mem_raddr),
    .o_mem_waddr(mem_waddr), .o_mem_din(mem_din), .o_mem_we(mem_we), .i_mem_dout(mem_dout),
    .o_busy(busy), .o_done(done), .o_err_flag(err_flag), .o_err_count(err_count),
    .o_first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  // Simple-dual-port read-first RAM with registered output.
  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_din;
    mem_dout <= ram[mem_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference verify: mismatch count and first mismatching address of the model memory.
  task automatic model_verify(input logic [DW-1:0] pat, output int cnt, output int first);
    cnt = 0;
    first = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (exp_mem[a] != pat) begin
        if (cnt == 0) first = a;
        cnt++;
      end
    end
  endtask

  task automatic model_fill(input logic [DW-1:0] pat);
    for (int a = 0; a < DEPTH; a++) exp_mem[a] = pat;
  endtask

  task automatic run_sweep(input logic mode, input logic [DW-1:0] pat, input int restart_at,
                           output int lat, output int ndone);
    cyc();
    cmd_start = 1'b1; cmd_mode = mode; cmd_pattern = pat; usr_valid = 1'b0;
    lat = -1;
    ndone = 0;
    for (int n = 1; n <= 5000; n++) begin
      cyc();
      if (n == restart_at) begin
        cmd_start = 1'b1; cmd_mode = ~mode; cmd_pattern = ~pat;
      end else begin
        cmd_start = 1'b0; cmd_mode = mode; cmd_pattern = pat;
      end
      #3;
      if (done) begin
        ndone++;
        if (lat < 0) lat = n;
      end
      if (lat >= 0 && n >= lat + 8) break;
    end
  endtask

  task automatic usr_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cyc();
    usr_valid = 1'b1; usr_we = 1'b1; usr_addr = a; usr_wdata = d;
    #3;
    chk("usr_write_ready", usr_ready, 1'b1);
    exp_mem[a] = d;
    cyc();
    usr_valid = 1'b0;
  endtask

  task automatic usr_read(input logic [AW-1:0] a);
    cyc();
    usr_valid = 1'b1; usr_we = 1'b0; usr_addr = a;
    cyc();
    usr_valid = 1'b0;
    #3;
    chk("usr_read_rvalid", usr_rvalid, 1'b1);
    chk("usr_read_rdata", usr_rdata, exp_mem[a]);
  endtask

  initial begin
    int lat, ndone, ecnt, efirst, drops, badgap, last_drop, eng_wr, bad_eng, notready, rd_bad;
    int found;
    logic prev_rd;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] p0, p1;

    reset = 1'b1; cmd_start = 1'b0; cmd_mode = 1'b0; cmd_pattern = '0;
    usr_valid = 1'b0; usr_we = 1'b0; usr_addr = '0; usr_wdata = '0;
    p0 = 18'h2AA00;
    p1 = DW'($urandom);
    if (p1 == p0) p1 = p0 ^ 18'h00001;

    #2;
    chk("reset_outputs_zero", |{busy, done, err_flag, err_count, first_err_addr, usr_ready,
        usr_rvalid, usr_rdata, mem_we, mem_raddr, mem_waddr, mem_din}, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    #3;
    chk("ready_before_first_clock", usr_ready, 1'b0);
    cyc(); #3;
    chk("ready_after_first_clock", usr_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);

    // Fill then verify without user traffic.
    run_sweep(1'b0, p0, 0, lat, ndone);
    model_fill(p0);
    chk("fill_latency", lat, DEPTH + 1);
    chk("fill_done_pulses", ndone, 1);
    chk("fill_busy_after", busy, 1'b0);
    ecnt = 0;
    for (int a = 0; a < DEPTH; a++) if (ram[a] !== exp_mem[a]) ecnt++;
    chk("fill_ram_contents", ecnt, 0);
    run_sweep(1'b1, p0, 0, lat, ndone);
    chk("verify_latency", lat, DEPTH + 2);
    chk("verify_err_flag", err_flag, 1'b0);
    chk("verify_err_count", err_count, 0);

    // Corrupt two words, then verify with a second start pulse mid-sweep.
    usr_write(12'd5, 18'h00001);
    usr_write(12'd4095, 18'h3FFFF);
    usr_read(12'd5);
    usr_read(12'd4095);
    model_verify(p0, ecnt, efirst);
    run_sweep(1'b1, p0, 2000, lat, ndone);
    chk("corrupt_latency", lat, DEPTH + 2);
    chk("corrupt_done_pulses", ndone, 1);
    chk("corrupt_err_count", err_count, ecnt);
    chk("corrupt_first_err", first_err_addr, efirst);
    chk("corrupt_err_flag", err_flag, 1'b1);

    // Fill with continuous user writes, then continuous user reads.
    cyc();
    cmd_start = 1'b1; cmd_mode = 1'b0; cmd_pattern = p0;
    drops = 0; badgap = 0; last_drop = 0; eng_wr = 0; bad_eng = 0;
    for (int n = 1; n <= 900; n++) begin
      cyc();
      cmd_start = 1'b0;
      usr_valid = 1'b1; usr_we = 1'b1; usr_addr = AW'($urandom); usr_wdata = p0;
      #3;
      if (!usr_ready) begin
        drops++;
        if (n - last_drop != SMAX + 1) badgap++;
        last_drop = n;
        if (!mem_we || mem_waddr != AW'(eng_wr) || mem_din != p0) bad_eng++;
        eng_wr++;
      end
    end
    chk("fillwr_drops", drops, 900 / (SMAX + 1));
    chk("fillwr_bad_gaps", badgap, 0);
    chk("fillwr_bad_engine_writes", bad_eng, 0);
    notready = 0; rd_bad = 0; prev_rd = 1'b0; prev_addr = '0;
    for (int n = 1; n <= 200; n++) begin
      cyc();
      usr_valid = 1'b1; usr_we = 1'b0; usr_addr = AW'(6 + ($urandom % (DEPTH - 7)));
      #3;
      if (!usr_ready) notready++;
      if (mem_we) begin
        if (mem_waddr != AW'(eng_wr) || mem_din != p0) bad_eng++;
        eng_wr++;
      end
      if (prev_rd) begin
        if (usr_rvalid !== 1'b1 || usr_rdata !== exp_mem[prev_addr]) rd_bad++;
      end else if (usr_rvalid !== 1'b0) rd_bad++;
      prev_rd = usr_ready; prev_addr = usr_addr;
    end
    chk("fillrd_never_stalled", notready, 0);
    chk("fillrd_bad_data", rd_bad, 0);
    chk("fillrd_engine_words", eng_wr, 300);
    chk("fillrd_bad_engine_writes", bad_eng, 0);
    lat = -1;
    for (int n = 1101; n <= 6000; n++) begin
      cyc();
      usr_valid = 1'b0;
      #3;
      if (done) begin
        lat = n;
        break;
      end
    end
    chk("fillwr_latency", lat, 900 + 200 + (DEPTH - 300) + 1);
    model_fill(p0);

    // Verify with a user read every cycle.
    cyc();
    cmd_start = 1'b1; cmd_mode = 1'b1; cmd_pattern = p0; usr_valid = 1'b0;
    drops = 0; badgap = 0; last_drop = 0; rd_bad = 0; prev_rd = 1'b0; lat = -1;
    for (int n = 1; n <= 40000; n++) begin
      cyc();
      cmd_start = 1'b0;
      usr_valid = 1'b1; usr_we = 1'b0; usr_addr = AW'($urandom);
      #3;
      if (!usr_ready) begin
        drops++;
        if (n - last_drop != SMAX + 1) badgap++;
        last_drop = n;
      end
      if (prev_rd) begin
        if (usr_rvalid !== 1'b1 || usr_rdata !== exp_mem[prev_addr]) rd_bad++;
      end else if (usr_rvalid !== 1'b0) rd_bad++;
      prev_rd = usr_ready; prev_addr = usr_addr;
      if (done) begin
        lat = n;
        break;
      end
    end
    usr_valid = 1'b0;
    model_verify(p0, ecnt, efirst);
    chk("vrd_drops", drops, DEPTH);
    chk("vrd_bad_gaps", badgap, 0);
    chk("vrd_bad_read_data", rd_bad, 0);
    chk("vrd_latency", lat, DEPTH * (SMAX + 1) + 2);
    chk("vrd_err_count", err_count, ecnt);

    // Reset in the middle of a fill with a new pattern.
    cyc();
    cmd_start = 1'b1; cmd_mode = 1'b0; cmd_pattern = p1;
    found = 0;
    for (int n = 1; n <= 300; n++) begin
      cyc();
      cmd_start = 1'b0;
      #3;
      if (mem_we && mem_waddr == 12'd100) begin
        found = 1;
        break;
      end
    end
    chk("midfill_reached_100", found, 1);
    reset = 1'b1;
    #1;
    chk("midfill_reset_zero", |{busy, done, err_flag, err_count, first_err_addr, usr_ready,
        usr_rvalid, usr_rdata, mem_we, mem_raddr, mem_waddr, mem_din}, 1'b0);
    for (int a = 0; a < 100; a++) exp_mem[a] = p1;
    cyc(); cyc();
    reset = 1'b0;
    #3;
    chk("midfill_ready_low", usr_ready, 1'b0);
    model_verify(p1, ecnt, efirst);
    run_sweep(1'b1, p1, 0, lat, ndone);
    chk("midfill_verify_latency", lat, DEPTH + 2);
    chk("midfill_err_count", err_count, ecnt);
    chk("midfill_first_err", first_err_addr, efirst);
    chk("midfill_err_flag", err_flag, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_scrub_ctrl.md
# mem_scrub_ctrl

Sequencer and arbiter for one simple-dual-port block RAM (one read port, one write port, registered read, 18 x 4096 by default). It shares the RAM between an external user port and a background engine. The engine either fills every word with a pattern or reads every word back and checks it against that pattern, so a reinitialised memory can be written and verified in-system. It sits directly in front of the RAM wrapper and owns all of the RAM's address, data and write-enable pins.

## Interface
- ADDR_W, 12, address width
- DATA_W, 18, word width
- DEPTH, 4096, words swept by the engine (≤ 2^ADDR_W)
- STALL_MAX, 8, consecutive user cycles allowed to block the engine before the engine is guaranteed one slot
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- cmd_start  in  1  one-cycle pulse that starts a sweep
- cmd_mode  in  1  0 = fill, 1 = verify (sampled with cmd_start)
- cmd_pattern  in  DATA_W  fill/expected word (sampled with cmd_start)
- usr_valid  in  1  user access request
- usr_we  in  1  1 = write, 0 = read
- usr_addr  in  ADDR_W  user address
- usr_wdata  in  DATA_W  user write data
- usr_ready  out  1  user access accepted this cycle
- usr_rvalid  out  1  read data valid
- usr_rdata  out  DATA_W  read data
- mem_raddr  out  ADDR_W  RAM read address
- mem_waddr  out  ADDR_W  RAM write address
- mem_din  out  DATA_W  RAM write data
- mem_we  out  1  RAM write enable
- mem_dout  in  DATA_W  RAM read data; valid 1 cycle after mem_raddr
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end
- err_flag  out  1  at least one verify mismatch in the last sweep
- err_count  out  ADDR_W+1  mismatches in the last sweep; saturates at DEPTH
- first_err_addr  out  ADDR_W  address of the first mismatch

## Operation
- **States:** IDLE, FILL, VERIFY, DRAIN, DONE.
- **IDLE:**
  - cmd_start captures mode and pattern.
  - It clears err_flag, err_count and first_err_addr.
  - It sets the engine address eaddr to 0.
  - It moves to FILL or VERIFY.
- **cmd_start outside IDLE:** ignored.
- **FILL:** each granted cycle writes cmd_pattern to eaddr.
- **VERIFY:** each granted cycle reads eaddr. The compare of mem_dout against the pattern happens the next cycle.
- **Engine address:** eaddr increments only on a granted cycle.
- **End of sweep:**
  - A grant at eaddr = DEPTH-1 goes FILL→DONE or VERIFY→DRAIN.
  - DRAIN performs the final compare, then goes to DONE.
  - DONE pulses done, then returns to IDLE.
- **Arbitration** applies per port and only when the user and the engine need the same port:
  - FILL conflicts with user writes.
  - VERIFY conflicts with user reads.
  - Non-conflicting accesses proceed in the same cycle.
- **Conflict winner:** the user wins, unless the stall counter has reached STALL_MAX. In that case usr_ready is low for one cycle, the engine is granted, and the counter clears.
- **Stall counter:** increments on each cycle the engine is blocked by the user, and clears on any engine grant.
- **In IDLE, DRAIN and DONE:** usr_ready = 1.
- **mem_we:** high only on a granted write. mem_waddr and mem_din are don't-care when mem_we is low.
- **Compare:** mismatch when mem_dout ≠ pattern.
  - On the first mismatch: latch its address into first_err_addr and set err_flag.
  - On every mismatch: increment err_count, saturating.
- **Reset, including mid-sweep:**
  - All state and outputs clear immediately; the state machine goes to IDLE.
  - RAM contents are not restored; a partially filled RAM stays partial.

## Timing
- **Reset values:** every output is 0 except usr_ready, which goes to 1 on the first clock after reset deasserts.
- **User read:** accepted at cycle t gives usr_rvalid = 1 with usr_rdata = mem_dout at t+1, for one cycle.
- **User write:** lands in the RAM at the edge ending the accepting cycle.
- **Read and write to the same address in one cycle:** the read returns the old data (read-first); the controller does not forward.
- **Fill sweep with no contention:** cmd_start at t gives FILL from t+1 to t+DEPTH, DONE at t+DEPTH+1. busy is high from t+1 through DONE; done is high at t+DEPTH+1.
- **Verify sweep with no contention:** DONE at t+DEPTH+2 (one extra DRAIN cycle).
- **Status stability:** err_count and first_err_addr are final in the cycle done is high and hold until the next cmd_start.
- **Worst-case engine throughput:** 1 word per STALL_MAX+1 cycles.

## Test plan
- **Fill, then verify, no user traffic:**
  - Stimulus: fill with pattern 0x2AA00, then verify with pattern 0x2AA00.
  - Required: fill done at cycle 4097 after start, verify done at cycle 4098 after start; err_flag = 0, err_count = 0.
- **Corrupted words:**
  - Stimulus: after a fill with 0x2AA00, user writes 0x00001 to address 5 and 0x3FFFF to address 4095; then verify with 0x2AA00.
  - Required: err_count = 2, first_err_addr = 5, err_flag = 1.
- **Continuous user reads during verify:**
  - Stimulus: usr_valid = 1 with usr_we = 0 every cycle during a verify sweep.
  - Required: usr_ready drops exactly once every 9 cycles; every accepted read returns the correct data one cycle later; the sweep completes with err_count = 0.
- **User writes during fill:**
  - Stimulus: user writes every cycle during a fill.
  - Required: the engine advances 1 word per 9 cycles.
  - Stimulus: user reads during the same fill.
  - Required: the reads are never stalled.
- **Reset mid-fill:**
  - Stimulus: assert reset at eaddr = 100.
  - Required: busy = 0 and all outputs 0 asynchronously; a new verify of the original pattern then reports mismatches from address 100 onward only.
- **cmd_start while busy:**
  - Stimulus: pulse cmd_start again during a sweep.
  - Required: ignored; exactly one done pulse; mode and pattern unchanged.
